vx_mat_dispatch_seq: RTL and testbench
======================================

Name: vx_mat_dispatch_seq

Overview:
- Arbitrates `NUM_REQS` dispatch streams (one per issue slice) onto a single shared matrix/ALU functional-unit dispatch port.
- Non-matrix ops (`m_type=0`) are single-beat and arbitrated round-robin.
- A matrix macro-op (`m_type=1`) locks the grant to its requester until `m_instr_cnt` beats carrying the same `m_instr_id` have been forwarded, so the beats of one macro-op are never interleaved.
- Sits between the dispatch units and the shared FU; the output is registered.

Parameters:
- NUM_REQS, 4, number of requesting dispatch streams (≥2).
- DATAW, 512, width of the opaque dispatch payload (packed dispatch `data_t`).
- M_INSTR_BITS, 4, width of the matrix instruction id.
- REQ_BITS, `$clog2(NUM_REQS)`, index width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  NUM_REQS  per-requester valid
- in_data  in  NUM_REQS*DATAW  per-requester payload, passed through unmodified
- in_m_type  in  NUM_REQS  1 = matrix beat
- in_m_cnt  in  NUM_REQS*4  beats in macro-op (`m_instr_cnt`)
- in_m_id  in  NUM_REQS*M_INSTR_BITS  macro-op id
- in_ready  out  NUM_REQS  per-requester ready (one-hot or zero)
- out_valid  out  1  FU dispatch valid
- out_data  out  DATAW  forwarded payload
- out_req_idx  out  REQ_BITS  source requester of current beat
- out_beat  out  4  beat index within macro-op (0 for non-matrix)
- out_last  out  1  final beat of op (always 1 for non-matrix)
- out_ready  in  1  FU ready
- busy  out  1  lock held
- proto_err  out  1  sticky protocol error

Behaviour:
Reset and output register
- Reset is asynchronous and active-low; `clk` is the only clock.
- On `reset` assertion, all outputs clear immediately: `out_valid=0`, `out_data=0`, `out_req_idx=0`, `out_beat=0`, `out_last=0`, `busy=0`, `proto_err=0`. The state machine goes to IDLE, the round-robin pointer to 0, the beat counter to 0.
- A reset in mid-macro-op abandons the lock. No further beats of that op are forwarded unless they are re-presented.
- The output stage is a single register. `load = |(in_valid & in_ready)`.
- `in_ready[g]=1` only for the granted index `g`, and only when `!out_valid || out_ready`. This gives full throughput, one beat per cycle.
- Latency is 1 cycle from accepted input to `out_valid`.
- `out_valid` stays high, with `out_data` and the side outputs stable, until `out_ready`.

State machine
- IDLE:
  - Grant goes to the first valid requester at or after `rr_ptr`, wrapping modulo `NUM_REQS`. If no requester is valid, there is no grant and `in_ready=0`.
  - On accept of a beat from `g`, set `rr_ptr=(g+1)%NUM_REQS`.
  - If the accepted beat has `m_type=1` and effective count > 1:
    - latch `lock_idx=g`, `lock_id=m_id`, `lock_cnt=eff_cnt`, `beat=1`;
    - go to LOCKED;
    - output `out_beat=0`, `out_last=0`.
  - Otherwise (non-matrix, or effective count ≤ 1), output `out_beat=0`, `out_last=1` and stay in IDLE.
- LOCKED:
  - Grant is fixed to `lock_idx`. Other requesters are held (`in_ready=0`) regardless of their valids.
  - A beat is accepted only when `in_valid[lock_idx]` is high, its `m_type=1` and its `m_id==lock_id`.
  - On accept: `out_beat=beat`, `out_last=(beat==lock_cnt-1)`, then `beat` increments.
  - On accepting the last beat, return to IDLE. `rr_ptr` is already past `lock_idx`.
  - If the locked requester presents a valid beat with `m_type=0` or a different `m_id`:
    - `in_ready=0` (stall, beat not consumed);
    - `proto_err` sets and is sticky until reset;
    - the state stays LOCKED.
- `busy` = (state==LOCKED).

Arithmetic and boundaries
- Effective count: `in_m_cnt=0` is treated as 1, so the op is a single beat with `out_last=1`. A count of 1 never enters LOCKED.
- `beat` is 4 bits. The maximum count of 15 yields beats 0..14, so there is no wrap.
- Backpressure: while `out_ready=0` with `out_valid=1`, no accept occurs, and `rr_ptr` and `beat` hold.
- Simultaneous drain and accept in the same cycle is a legal back-to-back transfer.

Test Plan:
- Round-robin: after reset, requesters 0–3 all hold single-beat ops, `out_ready=1` → `out_req_idx` sequence 0,1,2,3,0 on consecutive cycles; first `out_valid` 1 cycle after reset release plus the first valid.
- Matrix lock: req1 sends `m_type=1`, cnt=4, id=5 while req0/req2 are valid → four consecutive outputs from req1 with `out_beat` 0..3, `out_last` only on beat 3; `busy` high from the cycle after the first accept through the last accept; next grant goes to req2.
- Count zero/one: `m_type=1` with cnt=0, then cnt=1 → each gives a single output with `out_last=1`; `busy` never asserts.
- Backpressure: hold `out_ready=0` for 5 cycles mid-macro-op at beat 2 → `out_data`/`out_beat=2` stay stable, `in_ready=0`; on release, beats 3… resume without loss or duplication.
- Protocol error: while locked on id=5, req1 presents id=6 → `in_ready[1]=0`, `proto_err` goes to 1 and stays; no output.
- Async reset mid-op: assert `reset` low at beat 2 of 4 → all outputs are 0 immediately (no clock edge needed); after release, the arbiter starts from req0 in IDLE.

Source files
------------

// File: rtl/vx_mat_dispatch_seq.sv
`default_nettype none
// ============================================================================
// Module      : vx_mat_dispatch_seq
// Description : Arbitrates NUM_REQS dispatch streams onto one shared matrix/ALU
//               FU port. Single-beat ops go round-robin; a multi-beat matrix
//               macro-op locks the grant to its requester until every beat of
//               that macro-op id has been forwarded. Registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_mat_dispatch_seq #(
    parameter int NUM_REQS     = 4,
    parameter int DATAW        = 512,
    parameter int M_INSTR_BITS = 4,
    parameter int REQ_BITS     = $clog2(NUM_REQS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            in_valid,
    input  logic [NUM_REQS*DATAW-1:0]      in_data,
    input  logic [NUM_REQS-1:0]            in_m_type,
    input  logic [NUM_REQS*4-1:0]          in_m_cnt,
    input  logic [NUM_REQS*M_INSTR_BITS-1:0] in_m_id,
    output logic [NUM_REQS-1:0]            in_ready,
    output logic                           out_valid,
    output logic [DATAW-1:0]               out_data,
    output logic [REQ_BITS-1:0]            out_req_idx,
    output logic [3:0]                     out_beat,
    output logic                           out_last,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           proto_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  r_state;
    logic [REQ_BITS-1:0]     r_rr_ptr;
    logic [REQ_BITS-1:0]     r_lock_idx;
    logic [M_INSTR_BITS-1:0] r_lock_id;
    logic [3:0]              r_lock_cnt;
    logic [3:0]              r_beat;

    logic [DATAW-1:0]        w_data_arr [NUM_REQS];
    logic [3:0]              w_cnt_arr  [NUM_REQS];
    logic [M_INSTR_BITS-1:0] w_id_arr   [NUM_REQS];

    logic                    w_can_load;
    logic                    w_grant_vld;
    logic [REQ_BITS-1:0]     w_grant_idx;
    logic [REQ_BITS-1:0]     w_scan_idx;
    logic                    w_lock_match;
    logic                    w_proto_viol;
    logic                    w_load;
    logic [3:0]              w_sel_cnt;
    logic [3:0]              w_eff_cnt;
    logic                    w_sel_type;
    logic [REQ_BITS-1:0]     w_rr_next;
    logic                    w_last_beat;

    // Split the flat per-requester buses into indexable arrays
    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
            assign w_data_arr[gi] = in_data[gi*DATAW +: DATAW];
            assign w_cnt_arr[gi]  = in_m_cnt[gi*4 +: 4];
            assign w_id_arr[gi]   = in_m_id[gi*M_INSTR_BITS +: M_INSTR_BITS];
        end
    endgenerate

    // Output register can take a new beat when empty or draining this cycle
    assign w_can_load = !out_valid || out_ready;

    // Grant selection: fixed to the lock owner when locked, else round-robin scan
    always_comb begin
        w_grant_vld  = 1'b0;
        w_grant_idx  = '0;
        w_scan_idx   = '0;
        w_lock_match = 1'b0;
        w_proto_viol = 1'b0;
        if (r_state == ST_LOCKED) begin
            // Only a matrix beat of the same macro-op may continue the lock
            w_lock_match = in_m_type[r_lock_idx] && (w_id_arr[r_lock_idx] == r_lock_id);
            w_grant_vld  = in_valid[r_lock_idx] && w_lock_match;
            w_grant_idx  = r_lock_idx;
            w_proto_viol = in_valid[r_lock_idx] && !w_lock_match;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                w_scan_idx = REQ_BITS'((int'(r_rr_ptr) + i) % NUM_REQS);
                if (!w_grant_vld && in_valid[w_scan_idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = w_scan_idx;
                end
            end
        end
    end

    // One-hot ready toward the granted requester only
    always_comb begin
        in_ready = '0;
        if (w_grant_vld && w_can_load) begin
            in_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_load      = |(in_valid & in_ready);
    assign w_sel_cnt   = w_cnt_arr[w_grant_idx];
    // A zero count is treated as a single-beat op
    assign w_eff_cnt   = (w_sel_cnt == 4'd0) ? 4'd1 : w_sel_cnt;
    assign w_sel_type  = in_m_type[w_grant_idx];
    assign w_rr_next   = REQ_BITS'((int'(w_grant_idx) + 1) % NUM_REQS);
    assign w_last_beat = (r_beat == (r_lock_cnt - 4'd1));

    assign busy = (r_state == ST_LOCKED);

    // Arbitration state, beat tracking and the registered output stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_lock_idx  <= '0;
            r_lock_id   <= '0;
            r_lock_cnt  <= '0;
            r_beat      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_req_idx <= '0;
            out_beat    <= '0;
            out_last    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            if (w_proto_viol) begin
                proto_err <= 1'b1;
            end

            if (w_load) begin
                out_valid   <= 1'b1;
                out_data    <= w_data_arr[w_grant_idx];
                out_req_idx <= w_grant_idx;
                case (r_state)
                    ST_IDLE: begin
                        r_rr_ptr <= w_rr_next;
                        if (w_sel_type && (w_eff_cnt > 4'd1)) begin
                            r_lock_idx <= w_grant_idx;
                            r_lock_id  <= w_id_arr[w_grant_idx];
                            r_lock_cnt <= w_eff_cnt;
                            r_beat     <= 4'd1;
                            r_state    <= ST_LOCKED;
                            out_beat   <= 4'd0;
                            out_last   <= 1'b0;
                        end else begin
                            out_beat   <= 4'd0;
                            out_last   <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        out_beat <= r_beat;
                        out_last <= w_last_beat;
                        if (w_last_beat) begin
                            r_beat  <= 4'd0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_beat  <= r_beat + 4'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_mat_dispatch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_mat_dispatch_seq
// Description : Directed self-checking bench for vx_mat_dispatch_seq
//               (round-robin, matrix lock, count 0/1, backpressure,
//               protocol error, asynchronous reset mid-op).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_mat_dispatch_seq;

    localparam int c_n  = 4;
    localparam int c_dw = 16;
    localparam int c_ib = 4;

    logic                clk;
    logic                reset;
    logic [c_n-1:0]      in_valid;
    logic [c_n*c_dw-1:0] in_data;
    logic [c_n-1:0]      in_m_type;
    logic [c_n*4-1:0]    in_m_cnt;
    logic [c_n*c_ib-1:0] in_m_id;
    logic [c_n-1:0]      in_ready;
    logic                out_valid;
    logic [c_dw-1:0]     out_data;
    logic [1:0]          out_req_idx;
    logic [3:0]          out_beat;
    logic                out_last;
    logic                out_ready;
    logic                busy;
    logic                proto_err;

    int n_checks = 0;
    int n_errors = 0;

    vx_mat_dispatch_seq #(
        .NUM_REQS     (c_n),
        .DATAW        (c_dw),
        .M_INSTR_BITS (c_ib)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_m_type   (in_m_type),
        .in_m_cnt    (in_m_cnt),
        .in_m_id     (in_m_id),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_req_idx (out_req_idx),
        .out_beat    (out_beat),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic t,
                           input logic [3:0] c, input logic [3:0] id, input logic [15:0] d);
        in_valid[i]            = v;
        in_m_type[i]           = t;
        in_m_cnt[i*4 +: 4]     = c;
        in_m_id[i*c_ib +: c_ib] = id;
        in_data[i*c_dw +: c_dw] = d;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] idx,
                             input logic [3:0] bt, input logic lst);
        check_val({tag, "_valid"}, 32'(out_valid), 32'(v));
        check_val({tag, "_idx"},   32'(out_req_idx), 32'(idx));
        check_val({tag, "_beat"},  32'(out_beat), 32'(bt));
        check_val({tag, "_last"},  32'(out_last), 32'(lst));
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_m_type = '0;
        in_m_cnt  = '0;
        in_m_id   = '0;
        out_ready = 1'b1;

        // ---------------- reset state ----------------
        @(negedge clk);
        check_out("rst", 1'b0, 2'd0, 4'd0, 1'b0);
        check_val("rst_data", 32'(out_data), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_perr", 32'(proto_err), 32'h0);

        // ---------------- round-robin ----------------
        reset = 1'b1;
        for (int i = 0; i < c_n; i++) set_req(i, 1'b1, 1'b0, 4'd0, 4'd0, 16'(16'h0100 + i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_out("rr", 1'b1, 2'(k % 4), 4'd0, 1'b1);
            check_val("rr_data", 32'(out_data), 32'(16'h0100 + (k % 4)));
        end
        // rr_ptr now 1
        in_valid = '0;

        // ---------------- matrix lock ----------------
        set_req(0, 1'b1, 1'b0, 4'd0, 4'd0, 16'h0A00);
        set_req(1, 1'b1, 1'b1, 4'd4, 4'd5, 16'h1B00);
        set_req(2, 1'b1, 1'b0, 4'd0, 4'd0, 16'h2C00);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check_out("lock", 1'b1, 2'd1, 4'(b), (b == 3));
            check_val("lock_busy", 32'(busy), 32'(b != 3));
            if (b == 0) check_val("lock_hold_ready", 32'(in_ready), 32'b0010);
        end
        in_valid[1] = 1'b0;
        @(negedge clk);
        check_out("after_lock", 1'b1, 2'd2, 4'd0, 1'b1);
        in_valid[2] = 1'b0;
        @(negedge clk);
        check_out("after_lock2", 1'b1, 2'd0, 4'd0, 1'b1);
        in_valid = '0;
        // rr_ptr now 1

        // ---------------- count zero / one ----------------
        set_req(1, 1'b1, 1'b1, 4'd0, 4'd3, 16'h1D00);
        @(negedge clk);
        check_out("cnt0", 1'b1, 2'd1, 4'd0, 1'b1);
        check_val("cnt0_busy", 32'(busy), 32'h0);
        set_req(1, 1'b1, 1'b1, 4'd1, 4'd4, 16'h1E00);
        @(negedge clk);
        check_out("cnt1", 1'b1, 2'd1, 4'd0, 1'b1);
        check_val("cnt1_busy", 32'(busy), 32'h0);
        in_valid = '0;
        // rr_ptr now 2

        // ---------------- backpressure ----------------
        set_req(2, 1'b1, 1'b1, 4'd4, 4'd7, 16'h2000);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            check_out("bp", 1'b1, 2'd2, 4'(b), 1'b0);
            check_val("bp_data", 32'(out_data), 32'(16'h2000 + b));
            in_data[2*c_dw +: c_dw] = 16'(16'h2001 + b);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_out("bp_hold", 1'b1, 2'd2, 4'd2, 1'b0);
            check_val("bp_hold_data", 32'(out_data), 32'h2002);
            check_val("bp_hold_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_out("bp_resume", 1'b1, 2'd2, 4'd3, 1'b1);
        check_val("bp_resume_data", 32'(out_data), 32'h2003);
        in_valid = '0;
        @(negedge clk);
        check_val("bp_drain", 32'(out_valid), 32'h0);
        check_val("bp_drain_busy", 32'(busy), 32'h0);
        // rr_ptr now 3

        // ---------------- protocol error ----------------
        set_req(1, 1'b1, 1'b1, 4'd4, 4'd5, 16'h1500);
        @(negedge clk);
        check_out("perr_b0", 1'b1, 2'd1, 4'd0, 1'b0);
        in_m_id[1*c_ib +: c_ib] = 4'd6;
        #1;
        check_val("perr_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        check_val("perr_set", 32'(proto_err), 32'h1);
        check_val("perr_nout", 32'(out_valid), 32'h0);
        @(negedge clk);
        check_val("perr_sticky", 32'(proto_err), 32'h1);
        check_val("perr_busy", 32'(busy), 32'h1);

        // ---------------- async reset mid-op ----------------
        in_m_id[1*c_ib +: c_ib] = 4'd5;
        @(negedge clk);
        check_out("ar_b1", 1'b1, 2'd1, 4'd1, 1'b0);
        @(negedge clk);
        check_out("ar_b2", 1'b1, 2'd1, 4'd2, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check_out("ar_clr", 1'b0, 2'd0, 4'd0, 1'b0);
        check_val("ar_clr_data", 32'(out_data), 32'h0);
        check_val("ar_clr_busy", 32'(busy), 32'h0);
        check_val("ar_clr_perr", 32'(proto_err), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 4'd0, 4'd0, 16'h0F00);
        @(negedge clk);
        check_out("ar_first", 1'b1, 2'd0, 4'd0, 1'b1);
        in_valid[0] = 1'b0;
        @(negedge clk);
        check_out("ar_reop", 1'b1, 2'd1, 4'd0, 1'b0);
        check_val("ar_reop_busy", 32'(busy), 32'h1);
        in_valid = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
